pipemem_access: RTL

- MEM-stage access unit of the 5-stage pipelined MIPS CPU; consumes the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn).
- Drives a request/acknowledge data-memory bus with byte/halfword/word lane steering; returns aligned, extended load data toward the MEM/WB register.
- Stalls the pipeline while an access is outstanding; flags misaligned accesses.

---
 rtl/pipe_defs.sv | 16 +
 rtl/pipemem_align.sv | 53 +++++
 rtl/pipemem_access.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_defs.sv
// Shared definitions for the MEM-stage access unit: access size codes and
// the MEM FSM states.
package pipe_defs;

  // Access size codes carried on msize; 2'b11 is reserved and behaves as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

endpackage

// File: rtl/pipemem_align.sv
// Lane steering for the MEM stage: byte enables and replicated store data,
// plus load-data extraction with sign/zero extension. Purely combinational.
module pipemem_align
  import pipe_defs::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: select active lanes and replicate data across all lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Load side: pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    ld_byte = ld_raw[8*ld_off +: 8];
    ld_half = ld_raw[16*ld_off[1] +: 16];
    ld_data = ld_raw;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/pipemem_access.sv
// MEM-stage access unit: drives a req/ack data-memory bus, stalls the
// pipeline while an access is outstanding, flags misaligned accesses.
// Optional build macro PIPEMEM_TIMEOUT_EN adds a BUSY-cycle abort limit
// (TIMEOUT) reported on mbuserr; without it mbuserr is tied low.
module pipemem_access
  import pipe_defs::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  input  logic [1:0]  msize,
  input  logic        msext,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  input  logic        dack,
  output logic [31:0] mmo,
  output logic        mstall,
  output logic        mexc,
  output logic        mwreg_o,
  output logic [4:0]  mrn_o,
  output logic        mbuserr
);

  mem_state_e  state_q, state_d;
  logic        access, misaligned, start;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        dwe_q;
  logic [3:0]  dbe_q;
  logic [31:0] dwdata_q;
  logic [31:0] mmo_q;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

`ifdef PIPEMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             abort;
  logic             buserr_q;

  // Limit reached without an acknowledge; a same-cycle dack takes priority.
  assign abort   = (cnt_q == CNT_W'(TIMEOUT - 1)) && !dack;
  assign mbuserr = buserr_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign mbuserr        = 1'b0;
`endif

  assign access     = mm2reg | mwmem;
  assign misaligned = ((msize == SZ_HALF) & malu[0]) | (msize[1] & (|malu[1:0]));

  assign dreq    = (state_q == ST_BUSY);
  assign dwe     = dwe_q;
  assign daddr   = {addr_q[31:2], 2'b00};
  assign dbe     = dbe_q;
  assign dwdata  = dwdata_q;
  assign mmo     = mmo_q;
  assign mrn_o   = mrn;
  assign mwreg_o = mwreg & ~mexc;

  pipemem_align u_align (
    .st_size  (msize),
    .st_off   (malu[1:0]),
    .st_data  (mb),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_size  (size_q),
    .ld_off   (addr_q[1:0]),
    .ld_sext  (sext_q),
    .ld_raw   (drdata),
    .ld_data  (ld_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, stall and misalignment decode.
  always_comb begin
    state_d = state_q;
    mstall  = 1'b0;
    mexc    = 1'b0;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (misaligned) begin
            mexc = 1'b1;
          end else begin
            mstall  = 1'b1;
            start   = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        mstall = 1'b1;
        if (dack) state_d = ST_DONE;
`ifdef PIPEMEM_TIMEOUT_EN
        else if (abort) state_d = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch on BUSY entry and load-result capture on completion.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      addr_q   <= '0;
      size_q   <= '0;
      sext_q   <= 1'b0;
      dwe_q    <= 1'b0;
      dbe_q    <= '0;
      dwdata_q <= '0;
      mmo_q    <= '0;
`ifdef PIPEMEM_TIMEOUT_EN
      cnt_q    <= '0;
      buserr_q <= 1'b0;
`endif
    end else begin
`ifdef PIPEMEM_TIMEOUT_EN
      buserr_q <= 1'b0;
`endif
      if (start) begin
        addr_q   <= malu;
        size_q   <= msize;
        sext_q   <= msext;
        dwe_q    <= mwmem;
        dbe_q    <= st_be;
        dwdata_q <= st_wdata;
`ifdef PIPEMEM_TIMEOUT_EN
        cnt_q    <= '0;
`endif
      end else if (state_q == ST_BUSY) begin
        if (dack) begin
          if (!dwe_q) mmo_q <= ld_data;
        end
`ifdef PIPEMEM_TIMEOUT_EN
        else if (abort) begin
          mmo_q    <= '0;
          buserr_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
`endif
      end
    end
  end

endmodule
